// File: rtl/dm_access_pkg.sv
// Shared encodings and helpers for the data-memory access controller.
// Latency: none (types, constants and pure functions only).
// Backpressure: not applicable.
package dm_access_pkg;

  // Request size encodings
  localparam logic [1:0] SZ_B = 2'b00;
  localparam logic [1:0] SZ_H = 2'b01;
  localparam logic [1:0] SZ_W = 2'b10;
  localparam logic [1:0] SZ_X = 2'b11;

  typedef enum logic [1:0] {
    ST_IDLE = 2'd0,
    ST_RD   = 2'd1,
    ST_WR   = 2'd2,
    ST_RESP = 2'd3
  } state_t;

  // Byte lanes touched by an access of the given size at the given low address bits
  function automatic logic [3:0] lane_mask(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    lane_mask = 4'b0001 << lane;
      SZ_H:    lane_mask = 4'b0011 << {lane[1], 1'b0};
      SZ_W:    lane_mask = 4'b1111;
      default: lane_mask = 4'b0000;
    endcase
  endfunction

  // Half at odd address, word not on a 4-byte boundary, or the reserved size
  function automatic logic is_misaligned(input logic [1:0] size, input logic [1:0] lane);
    case (size)
      SZ_B:    is_misaligned = 1'b0;
      SZ_H:    is_misaligned = lane[0];
      SZ_W:    is_misaligned = |lane;
      default: is_misaligned = 1'b1;
    endcase
  endfunction

endpackage

// File: rtl/dm_access_ctrl_if.sv
// CPU-side request/response bundle of the data-memory access controller.
// Latency: none (wires only).
// Backpressure: req_valid/req_ready handshake; responses cannot be stalled.
interface dm_access_ctrl_if;
  logic        req_valid;
  logic        req_ready;
  logic        req_we;
  logic [1:0]  req_size;
  logic        req_signed;
  logic [31:0] req_addr;
  logic [31:0] req_wdata;
  logic        rsp_valid;
  logic [31:0] rsp_rdata;
  logic        rsp_misalign;

  // CPU / MEM-stage side
  modport master (
    output req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    input  req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );

  // Controller side
  modport slave (
    input  req_valid, req_we, req_size, req_signed, req_addr, req_wdata,
    output req_ready, rsp_valid, rsp_rdata, rsp_misalign
  );
endinterface

// File: rtl/dm_lane_unit.sv
// Byte-lane steering: load extract + zero/sign extend, and sub-word store merge.
// Latency: combinational.
// Backpressure: none; purely a function of its inputs.
module dm_lane_unit
  import dm_access_pkg::*;
(
  input  logic [31:0] word,
  input  logic [1:0]  lane,
  input  logic [1:0]  size,
  input  logic        sgn,
  input  logic [31:0] wdata,
  output logic [31:0] load_data,
  output logic [31:0] store_word
);
  logic [31:0] shifted;
  logic [31:0] wd_shift;
  logic [3:0]  mask;

  // Shift the addressed lane down for loads and up for stores, then extend or merge
  always_comb begin
    shifted    = word >> {lane, 3'b000};
    wd_shift   = wdata << {lane, 3'b000};
    mask       = lane_mask(size, lane);
    load_data  = word;
    store_word = word;
    case (size)
      SZ_B:    load_data = {{24{sgn & shifted[7]}}, shifted[7:0]};
      SZ_H:    load_data = {{16{sgn & shifted[15]}}, shifted[15:0]};
      default: load_data = word;
    endcase
    for (int i = 0; i < 4; i++) begin
      if (mask[i]) store_word[8*i +: 8] = wd_shift[8*i +: 8];
    end
  end

endmodule

// File: rtl/dm_access_ctrl.sv
// Turns byte/half/word CPU loads and stores into word-wide DM accesses (RMW for sub-word stores).
// Latency: load 2 clk, word store 2 clk, sub-word store 3 clk, fault 1 clk from accept to rsp_valid.
// Backpressure: req_ready only in IDLE; response is never stalled.
module dm_access_ctrl
  import dm_access_pkg::*;
#(
  parameter int DM_AW    = 10,
  parameter bit RSP_HOLD = 1'b0
) (
  input  logic            clk,
  input  logic            reset,
  dm_access_ctrl_if.slave cpu,
  output logic [32:0]     dm_addr,
  output logic [31:0]     dm_wdata,
  output logic            dm_we,
  input  logic [31:0]     dm_rdata
);
  state_t      state;
  logic [1:0]  r_lane;
  logic [1:0]  r_size;
  logic        r_sgn;
  logic        r_we;
  logic [31:0] r_wdata;
  logic        rsp_valid;
  logic        rsp_misalign;
  logic [31:0] rsp_rdata;
  logic [31:0] load_data;
  logic [31:0] store_word;
  logic [32:0] req_word_addr;

  // Word-aligned DM address; bits above the memory's own range are forwarded untouched
  assign req_word_addr = {1'b0, cpu.req_addr[31:DM_AW], cpu.req_addr[DM_AW-1:2], 2'b00};

  assign cpu.req_ready    = (state == ST_IDLE);
  assign cpu.rsp_valid    = rsp_valid;
  assign cpu.rsp_rdata    = rsp_rdata;
  assign cpu.rsp_misalign = rsp_misalign;

  // Write enable comes straight from the state register so a reset kills it at once
  assign dm_we = (state == ST_WR);

  dm_lane_unit u_lane (
    .word       (dm_rdata),
    .lane       (r_lane),
    .size       (r_size),
    .sgn        (r_sgn),
    .wdata      (r_wdata),
    .load_data  (load_data),
    .store_word (store_word)
  );

  // Access sequencer: IDLE -> [RD] -> [WR] -> RESP -> IDLE with registered DM and response outputs
  always_ff @(posedge clk or negedge reset) begin
    if (!reset) begin
      state        <= ST_IDLE;
      r_lane       <= 2'b00;
      r_size       <= SZ_B;
      r_sgn        <= 1'b0;
      r_we         <= 1'b0;
      r_wdata      <= '0;
      dm_addr      <= '0;
      dm_wdata     <= '0;
      rsp_valid    <= 1'b0;
      rsp_rdata    <= '0;
      rsp_misalign <= 1'b0;
    end else begin
      case (state)
        ST_IDLE: begin
          if (cpu.req_valid) begin
            r_lane       <= cpu.req_addr[1:0];
            r_size       <= cpu.req_size;
            r_sgn        <= cpu.req_signed;
            r_we         <= cpu.req_we;
            r_wdata      <= cpu.req_wdata;
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
            if (is_misaligned(cpu.req_size, cpu.req_addr[1:0])) begin
              // Faults skip the memory entirely
              rsp_valid    <= 1'b1;
              rsp_misalign <= 1'b1;
              state        <= ST_RESP;
            end else if (cpu.req_we && cpu.req_size == SZ_W) begin
              // Full word needs no read of the old contents
              dm_addr  <= req_word_addr;
              dm_wdata <= cpu.req_wdata;
              state    <= ST_WR;
            end else begin
              dm_addr <= req_word_addr;
              state   <= ST_RD;
            end
          end
        end
        ST_RD: begin
          if (r_we) begin
            dm_wdata <= store_word;
            state    <= ST_WR;
          end else begin
            rsp_rdata <= load_data;
            rsp_valid <= 1'b1;
            dm_addr   <= '0;
            state     <= ST_RESP;
          end
        end
        ST_WR: begin
          dm_addr   <= '0;
          dm_wdata  <= '0;
          rsp_rdata <= '0;
          rsp_valid <= 1'b1;
          state     <= ST_RESP;
        end
        ST_RESP: begin
          if (!RSP_HOLD) begin
            rsp_valid    <= 1'b0;
            rsp_rdata    <= '0;
            rsp_misalign <= 1'b0;
          end
          state <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule

// File: tb/tb_dm_access_ctrl.sv
// Self-checking bench for dm_access_ctrl against a byte-array reference memory model.
// Latency: n/a (bench).
// Backpressure: n/a (bench).
module tb_dm_access_ctrl;
  import dm_access_pkg::*;

  logic clk = 1'b0;
  logic reset = 1'b0;
  always #5 clk = ~clk;

  dm_access_ctrl_if bus ();
  logic [32:0] dm_addr;
  logic [31:0] dm_wdata;
  logic [31:0] dm_rdata;
  logic        dm_we;

  dm_access_ctrl #(.DM_AW(10), .RSP_HOLD(1'b0)) dut (
    .clk      (clk),
    .reset    (reset),
    .cpu      (bus),
    .dm_addr  (dm_addr),
    .dm_wdata (dm_wdata),
    .dm_we    (dm_we),
    .dm_rdata (dm_rdata)
  );

  // DM model: 1 KiB, combinational read, 4-byte write on posedge, plus a backdoor preload port
  logic [7:0] mem [0:1023];
  logic [7:0] ref_mem [0:1023];
  logic [9:0] ma;
  logic       bd_vld = 1'b0;
  logic [9:0] bd_addr = '0;
  logic [31:0] bd_dat = '0;
  int we_edges = 0;
  int n_checks = 0;
  int n_fail = 0;

  assign ma = dm_addr[9:0];
  assign dm_rdata = {mem[ma + 10'd3], mem[ma + 10'd2], mem[ma + 10'd1], mem[ma]};

  always @(posedge clk) begin
    if (dm_we) begin
      mem[ma]         <= dm_wdata[7:0];
      mem[ma + 10'd1] <= dm_wdata[15:8];
      mem[ma + 10'd2] <= dm_wdata[23:16];
      mem[ma + 10'd3] <= dm_wdata[31:24];
      we_edges        <= we_edges + 1;
    end
    if (bd_vld) begin
      mem[bd_addr]         <= bd_dat[7:0];
      mem[bd_addr + 10'd1] <= bd_dat[15:8];
      mem[bd_addr + 10'd2] <= bd_dat[23:16];
      mem[bd_addr + 10'd3] <= bd_dat[31:24];
    end
  end

  // ---------------- reference model ----------------
  function automatic logic ref_misalign(input logic [1:0] sz, input logic [31:0] a);
    int n;
    if (sz == 2'b11) return 1'b1;
    n = 1 << sz;
    return (a % n) != 0;
  endfunction

  function automatic logic [31:0] ref_load(input logic [31:0] a, input logic [1:0] sz, input logic sg);
    int n;
    longint v;
    logic [9:0] ix;
    n = 1 << sz;
    v = 0;
    for (int i = 0; i < n; i++) begin
      ix = a[9:0] + 10'(i);
      v = v + (longint'(ref_mem[ix]) << (8 * i));
    end
    if (sg && n < 4 && v >= (64'sd1 <<< (8 * n - 1))) v = v - (64'sd1 <<< (8 * n));
    return v[31:0];
  endfunction

  task automatic ref_store(input logic [31:0] a, input logic [1:0] sz, input logic [31:0] wd);
    int n;
    logic [9:0] ix;
    n = 1 << sz;
    for (int i = 0; i < n; i++) begin
      ix = a[9:0] + 10'(i);
      ref_mem[ix] = 8'(wd >> (8 * i));
    end
  endtask

  function automatic int ref_lat(input logic we, input logic [1:0] sz, input logic [31:0] a);
    if (ref_misalign(sz, a)) return 1;
    if (!we) return 2;
    return (sz == 2'b10) ? 2 : 3;
  endfunction

  task automatic bd_write(input logic [31:0] a, input logic [31:0] v);
    @(negedge clk);
    bd_vld = 1'b1; bd_addr = a[9:0]; bd_dat = v;
    @(negedge clk);
    bd_vld = 1'b0;
    ref_store(a, 2'b10, v);
  endtask

  // One request: returns response fields, latency from accept cycle, DM write pulses, first dm_we cycle
  task automatic do_req(input logic we, input logic [1:0] sz, input logic sg, input logic [31:0] a,
                        input logic [31:0] wd, output logic [31:0] rdata, output logic mis,
                        output int lat, output int pulses, output int we_at,
                        output logic [32:0] addr_c1, output logic rsp_after, output logic tmo);
    int n;
    int w0;
    tmo = 1'b0; lat = 0; we_at = -1; addr_c1 = '0; rdata = '0; mis = 1'b0; pulses = 0; rsp_after = 1'b0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = we; bus.req_size = sz; bus.req_signed = sg;
    bus.req_addr = a; bus.req_wdata = wd;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) begin
      tmo = 1'b1;
      bus.req_valid = 1'b0;
      return;
    end
    w0 = we_edges;
    @(negedge clk);
    // Scramble the request after accept: the controller must have registered it
    bus.req_valid = 1'b0; bus.req_addr = $urandom; bus.req_wdata = $urandom;
    bus.req_size = 2'($urandom); bus.req_we = 1'($urandom); bus.req_signed = 1'($urandom);
    lat = 1;
    addr_c1 = dm_addr;
    while (bus.rsp_valid !== 1'b1 && lat < 20) begin
      if (dm_we === 1'b1 && we_at < 0) we_at = lat;
      @(negedge clk);
      lat++;
    end
    if (lat >= 20) tmo = 1'b1;
    rdata = bus.rsp_rdata;
    mis = bus.rsp_misalign;
    @(negedge clk);
    rsp_after = bus.rsp_valid;
    pulses = we_edges - w0;
  endtask

  // ---------------- tests ----------------
  task automatic test_reset();
    reset = 1'b0;
    repeat (2) @(negedge clk);
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL reset_req_ready got %b want 1", bus.req_ready); end
    n_checks++; if (bus.rsp_valid !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_valid got %b want 0", bus.rsp_valid); end
    n_checks++; if (bus.rsp_rdata !== 32'h0) begin n_fail++; $display("FAIL reset_rsp_rdata got %h want 0", bus.rsp_rdata); end
    n_checks++; if (bus.rsp_misalign !== 1'b0) begin n_fail++; $display("FAIL reset_rsp_misalign got %b want 0", bus.rsp_misalign); end
    n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL reset_dm_we got %b want 0", dm_we); end
    n_checks++; if (dm_addr !== 33'h0) begin n_fail++; $display("FAIL reset_dm_addr got %h want 0", dm_addr); end
    n_checks++; if (dm_wdata !== 32'h0) begin n_fail++; $display("FAIL reset_dm_wdata got %h want 0", dm_wdata); end
    reset = 1'b1;
    @(negedge clk);
  endtask

  task automatic test_loads();
    logic [1:0]  t_sz [4] = '{SZ_B, SZ_B, SZ_H, SZ_H};
    logic        t_sg [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [31:0] t_a  [4] = '{32'h101, 32'h101, 32'h102, 32'h102};
    logic [31:0] t_e  [4] = '{32'hFFFFFFAA, 32'h000000AA, 32'hFFFF8899, 32'h00008899};
    logic [31:0] rd; logic mis, ra, tmo; int lat, pul, wa; logic [32:0] ac;
    bd_write(32'h100, 32'h8899AABB);
    for (int k = 0; k < 4; k++) begin
      do_req(1'b0, t_sz[k], t_sg[k], t_a[k], $urandom, rd, mis, lat, pul, wa, ac, ra, tmo);
      n_checks++; if (tmo !== 1'b0) begin n_fail++; $display("FAIL load%0d_timeout got %b want 0", k, tmo); end
      n_checks++; if (rd !== t_e[k]) begin n_fail++; $display("FAIL load%0d_rdata got %h want %h", k, rd, t_e[k]); end
      n_checks++; if (rd !== ref_load(t_a[k], t_sz[k], t_sg[k])) begin n_fail++; $display("FAIL load%0d_model got %h want %h", k, rd, ref_load(t_a[k], t_sz[k], t_sg[k])); end
      n_checks++; if (lat != 2) begin n_fail++; $display("FAIL load%0d_latency got %0d want 2", k, lat); end
      n_checks++; if (mis !== 1'b0 || pul != 0) begin n_fail++; $display("FAIL load%0d_side got mis=%b pulses=%0d want 0/0", k, mis, pul); end
      n_checks++; if (ac !== 33'h100) begin n_fail++; $display("FAIL load%0d_dm_addr got %h want 100", k, ac); end
      n_checks++; if (ra !== 1'b0) begin n_fail++; $display("FAIL load%0d_rsp_pulse got %b want 0", k, ra); end
    end
  endtask

  task automatic test_store_byte();
    logic [31:0] rd; logic mis, ra, tmo; int lat, pul, wa; logic [32:0] ac;
    bd_write(32'h100, 32'h11223344);
    do_req(1'b1, SZ_B, 1'b0, 32'h103, 32'hA5A5A55C, rd, mis, lat, pul, wa, ac, ra, tmo);
    ref_store(32'h103, SZ_B, 32'hA5A5A55C);
    n_checks++; if (pul != 1) begin n_fail++; $display("FAIL sb_we_pulses got %0d want 1", pul); end
    n_checks++; if (wa != 2) begin n_fail++; $display("FAIL sb_we_cycle got %0d want 2", wa); end
    n_checks++; if (lat != 3 || tmo !== 1'b0) begin n_fail++; $display("FAIL sb_latency got %0d want 3", lat); end
    n_checks++; if (rd !== 32'h0 || mis !== 1'b0) begin n_fail++; $display("FAIL sb_rsp got %h/%b want 0/0", rd, mis); end
    do_req(1'b0, SZ_W, 1'b0, 32'h100, 32'h0, rd, mis, lat, pul, wa, ac, ra, tmo);
    n_checks++; if (rd !== 32'h5C223344) begin n_fail++; $display("FAIL sb_readback got %h want 5c223344", rd); end
    n_checks++; if (rd !== ref_load(32'h100, SZ_W, 1'b0)) begin n_fail++; $display("FAIL sb_model got %h want %h", rd, ref_load(32'h100, SZ_W, 1'b0)); end
  endtask

  task automatic test_word();
    logic [31:0] rd; logic mis, ra, tmo; int lat, pul, wa; logic [32:0] ac;
    do_req(1'b1, SZ_W, 1'b0, 32'h200, 32'hDEADBEEF, rd, mis, lat, pul, wa, ac, ra, tmo);
    ref_store(32'h200, SZ_W, 32'hDEADBEEF);
    n_checks++; if (pul != 1 || wa != 1) begin n_fail++; $display("FAIL sw_we got pulses=%0d at=%0d want 1/1", pul, wa); end
    n_checks++; if (lat != 2) begin n_fail++; $display("FAIL sw_latency got %0d want 2", lat); end
    do_req(1'b0, SZ_W, 1'b0, 32'h200, 32'h0, rd, mis, lat, pul, wa, ac, ra, tmo);
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL lw_readback got %h want deadbeef", rd); end
    // Upper address bits reach dm_addr unchanged; the DM model only decodes the low 10
    do_req(1'b0, SZ_W, 1'b0, 32'h80000203 & 32'hFFFFFFFC, 32'h0, rd, mis, lat, pul, wa, ac, ra, tmo);
    n_checks++; if (ac !== 33'h080000200) begin n_fail++; $display("FAIL passthru_dm_addr got %h want 080000200", ac); end
    n_checks++; if (rd !== 32'hDEADBEEF) begin n_fail++; $display("FAIL passthru_rdata got %h want deadbeef", rd); end
  endtask

  task automatic test_faults();
    logic        t_we [3] = '{1'b1, 1'b0, 1'b0};
    logic [1:0]  t_sz [3] = '{SZ_H, SZ_W, SZ_X};
    logic [31:0] t_a  [3] = '{32'h201, 32'h202, 32'h200};
    logic [31:0] rd; logic mis, ra, tmo; int lat, pul, wa; logic [32:0] ac;
    for (int k = 0; k < 3; k++) begin
      do_req(t_we[k], t_sz[k], 1'b1, t_a[k], 32'hFFFFFFFF, rd, mis, lat, pul, wa, ac, ra, tmo);
      n_checks++; if (mis !== 1'b1) begin n_fail++; $display("FAIL fault%0d_misalign got %b want 1", k, mis); end
      n_checks++; if (rd !== 32'h0) begin n_fail++; $display("FAIL fault%0d_rdata got %h want 0", k, rd); end
      n_checks++; if (pul != 0 || wa != -1) begin n_fail++; $display("FAIL fault%0d_dm_we got pulses=%0d at=%0d want 0/-1", k, pul, wa); end
      n_checks++; if (lat != 1) begin n_fail++; $display("FAIL fault%0d_latency got %0d want 1", k, lat); end
      n_checks++; if (ac !== 33'h0) begin n_fail++; $display("FAIL fault%0d_dm_addr got %h want 0", k, ac); end
    end
    do_req(1'b0, SZ_W, 1'b0, 32'h200, 32'h0, rd, mis, lat, pul, wa, ac, ra, tmo);
    n_checks++; if (rd !== ref_load(32'h200, SZ_W, 1'b0)) begin n_fail++; $display("FAIL fault_mem_intact got %h want %h", rd, ref_load(32'h200, SZ_W, 1'b0)); end
  endtask

  task automatic test_reset_mid_rmw();
    int n, w0;
    logic [31:0] word;
    bd_write(32'h104, 32'hCAFEF00D);
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = 1'b1; bus.req_size = SZ_B; bus.req_signed = 1'b0;
    bus.req_addr = 32'h104; bus.req_wdata = 32'h77;
    n = 0;
    while (bus.req_ready !== 1'b1 && n < 20) begin @(negedge clk); n++; end
    w0 = we_edges;
    @(negedge clk);
    bus.req_valid = 1'b0;
    #1 reset = 1'b0;
    #1;
    n_checks++; if (bus.req_ready !== 1'b1) begin n_fail++; $display("FAIL midrmw_req_ready got %b want 1", bus.req_ready); end
    n_checks++; if (dm_we !== 1'b0) begin n_fail++; $display("FAIL midrmw_dm_we got %b want 0", dm_we); end
    n_checks++; if (dm_addr !== 33'h0) begin n_fail++; $display("FAIL midrmw_dm_addr got %h want 0", dm_addr); end
    repeat (2) @(negedge clk);
    reset = 1'b1;
    repeat (2) @(negedge clk);
    word = {mem[10'h107], mem[10'h106], mem[10'h105], mem[10'h104]};
    n_checks++; if (word !== 32'hCAFEF00D) begin n_fail++; $display("FAIL midrmw_mem got %h want cafef00d", word); end
    n_checks++; if (we_edges != w0) begin n_fail++; $display("FAIL midrmw_we_edges got %0d want %0d", we_edges, w0); end
  endtask

  task automatic test_back_to_back();
    logic        q_we [4] = '{1'b1, 1'b0, 1'b1, 1'b0};
    logic [1:0]  q_sz [4] = '{SZ_W, SZ_B, SZ_H, SZ_H};
    logic        q_sg [4] = '{1'b0, 1'b0, 1'b0, 1'b1};
    logic [31:0] q_a  [4] = '{32'h220, 32'h223, 32'h222, 32'h222};
    logic [31:0] q_wd [4] = '{32'h13579BDF, 32'h0, 32'h1234BEEF, 32'h0};
    logic [31:0] exp_q [$];
    int acc, rsp, outst, cyc;
    logic took;
    acc = 0; rsp = 0; outst = 0; cyc = 0;
    @(negedge clk);
    bus.req_valid = 1'b1; bus.req_we = q_we[0]; bus.req_size = q_sz[0]; bus.req_signed = q_sg[0];
    bus.req_addr = q_a[0]; bus.req_wdata = q_wd[0];
    while (rsp < 4 && cyc < 200) begin
      took = 1'b0;
      if (bus.rsp_valid === 1'b1) begin
        n_checks++; if (exp_q.size() == 0 || bus.rsp_rdata !== exp_q[0]) begin n_fail++; $display("FAIL b2b_rsp%0d got %h want %h", rsp, bus.rsp_rdata, (exp_q.size() != 0) ? exp_q[0] : 32'hx); end
        if (exp_q.size() != 0) void'(exp_q.pop_front());
        rsp++; outst--;
      end
      if (bus.req_ready === 1'b1 && acc < 4) begin
        n_checks++; if (outst != 0) begin n_fail++; $display("FAIL b2b_accept_busy got outstanding=%0d want 0", outst); end
        if (q_we[acc]) begin ref_store(q_a[acc], q_sz[acc], q_wd[acc]); exp_q.push_back(32'h0); end
        else exp_q.push_back(ref_load(q_a[acc], q_sz[acc], q_sg[acc]));
        acc++; outst++; took = 1'b1;
      end
      @(negedge clk);
      cyc++;
      if (took) begin
        if (acc < 4) begin
          bus.req_we = q_we[acc]; bus.req_size = q_sz[acc]; bus.req_signed = q_sg[acc];
          bus.req_addr = q_a[acc]; bus.req_wdata = q_wd[acc];
        end else bus.req_valid = 1'b0;
      end
    end
    bus.req_valid = 1'b0;
    n_checks++; if (acc != 4 || rsp != 4) begin n_fail++; $display("FAIL b2b_counts got acc=%0d rsp=%0d want 4/4", acc, rsp); end
  endtask

  task automatic test_random();
    logic we, sg, mis, ra, tmo, emis;
    logic [1:0] sz;
    logic [31:0] a, wd, rd, erd, mw;
    int lat, pul, wa;
    logic [32:0] ac;
    for (int i = 0; i < 16; i++) bd_write(32'h300 + 32'(4 * i), $urandom);
    for (int i = 0; i < 40; i++) begin
      we = 1'($urandom); sg = 1'($urandom); sz = 2'($urandom);
      a = 32'h300 + 32'($urandom_range(0, 59)); wd = $urandom;
      emis = ref_misalign(sz, a);
      erd = 32'h0;
      if (!emis && !we) erd = ref_load(a, sz, sg);
      do_req(we, sz, sg, a, wd, rd, mis, lat, pul, wa, ac, ra, tmo);
      if (!emis && we) ref_store(a, sz, wd);
      n_checks++; if (rd !== erd) begin n_fail++; $display("FAIL rnd%0d_rdata got %h want %h", i, rd, erd); end
      n_checks++; if (mis !== emis) begin n_fail++; $display("FAIL rnd%0d_misalign got %b want %b", i, mis, emis); end
      n_checks++; if (lat != ref_lat(we, sz, a)) begin n_fail++; $display("FAIL rnd%0d_latency got %0d want %0d", i, lat, ref_lat(we, sz, a)); end
      n_checks++; if (pul != ((!emis && we) ? 1 : 0)) begin n_fail++; $display("FAIL rnd%0d_we_pulses got %0d want %0d", i, pul, (!emis && we) ? 1 : 0); end
    end
    for (int i = 0; i < 16; i++) begin
      a = 32'h300 + 32'(4 * i);
      mw = {mem[a[9:0] + 10'd3], mem[a[9:0] + 10'd2], mem[a[9:0] + 10'd1], mem[a[9:0]]};
      n_checks++; if (mw !== ref_load(a, SZ_W, 1'b0)) begin n_fail++; $display("FAIL rnd_mem_%h got %h want %h", a, mw, ref_load(a, SZ_W, 1'b0)); end
    end
  endtask

  initial begin
    bus.req_valid = 1'b0; bus.req_we = 1'b0; bus.req_size = SZ_B; bus.req_signed = 1'b0;
    bus.req_addr = '0; bus.req_wdata = '0;
    test_reset();
    test_loads();
    test_store_byte();
    test_word();
    test_faults();
    test_reset_mid_rmw();
    test_back_to_back();
    test_random();
    $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
    $finish;
  end

  initial begin
    #500000;
    $display("FAIL watchdog expired at %0t", $time);
    $fatal(1, "watchdog");
  end

endmodule
